// File: rtl/pipeline_mem_arbiter.sv
// Shares one memory port between the fetch (IF) and memory (IM) stages: arbitrates, sequences
// each access with a latency counter, returns data with a one-cycle valid pulse, drives stalls.
module pipeline_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        im_req,
  input  logic [31:0] im_addr,
  input  logic [31:0] im_wdata,
  input  logic        im_rw,
  input  logic [1:0]  im_access_size,
  output logic [31:0] im_rdata,
  output logic        im_valid,
  output logic        im_err,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_pipe
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StImBusy} state_e;

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_if_rdata, r_im_rdata, r_mem_addr, r_mem_wdata;
  logic             r_if_valid, r_im_valid, r_im_err, r_mem_enable, r_mem_rw;
  logic [1:0]       r_mem_size;

  logic w_done, w_arb, w_im_misalign, w_im_elig, w_if_elig;
  logic w_im_grant, w_im_error, w_if_grant;

  always_comb begin
    w_done = (r_state != StIdle) && (r_cnt == '0);
    w_arb  = (r_state == StIdle) || w_done;
    w_im_misalign = 1'b1;
    case (im_access_size)
      2'b00:   w_im_misalign = 1'b0;
      2'b01:   w_im_misalign = im_addr[0];
      2'b10:   w_im_misalign = |im_addr[1:0];
      default: w_im_misalign = 1'b1;
    endcase
    // The requester finishing on this edge is excluded, which makes continuous requests alternate.
    w_im_elig  = im_req && (r_state != StImBusy);
    w_if_elig  = if_req && (r_state != StIfBusy);
    w_im_grant = w_arb && w_im_elig && !w_im_misalign;
    w_im_error = w_arb && w_im_elig && w_im_misalign;
    w_if_grant = w_arb && w_if_elig && !w_im_grant;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_im_grant)      w_state_next = StImBusy;
    else if (w_if_grant) w_state_next = StIfBusy;
    else if (w_done)     w_state_next = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_if_rdata   <= '0;
      r_im_rdata   <= '0;
      r_if_valid   <= 1'b0;
      r_im_valid   <= 1'b0;
      r_im_err     <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_rw     <= 1'b0;
      r_mem_size   <= 2'b00;
    end else begin
      r_if_valid <= 1'b0;
      r_im_valid <= 1'b0;
      r_im_err   <= w_im_error;
      if (r_state != StIdle && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_done) begin
        if (r_state == StIfBusy) begin
          r_if_rdata <= mem_rdata;
          r_if_valid <= 1'b1;
        end else begin
          if (!r_mem_rw) r_im_rdata <= mem_rdata;
          r_im_valid <= 1'b1;
        end
      end
      if (w_im_grant) begin
        r_mem_enable <= 1'b1;
        r_mem_addr   <= im_addr;
        r_mem_wdata  <= im_wdata;
        r_mem_rw     <= im_rw;
        r_mem_size   <= im_access_size;
        r_cnt        <= CNT_W'(MEM_LATENCY - 1);
      end else if (w_if_grant) begin
        r_mem_enable <= 1'b1;
        r_mem_addr   <= if_addr;
        r_mem_wdata  <= '0;
        r_mem_rw     <= 1'b0;
        r_mem_size   <= 2'b10;
        r_cnt        <= CNT_W'(MEM_LATENCY - 1);
      end else if (w_done) begin
        r_mem_enable <= 1'b0;
      end
    end
  end

  assign if_rdata        = r_if_rdata;
  assign if_valid        = r_if_valid;
  assign im_rdata        = r_im_rdata;
  assign im_valid        = r_im_valid;
  assign im_err          = r_im_err;
  assign mem_enable      = r_mem_enable;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_rw          = r_mem_rw;
  assign mem_access_size = r_mem_size;
  assign stall_if        = if_req & ~if_valid;
  assign stall_pipe      = im_req & ~(im_valid | im_err);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter: IM decode table plus hand sequences for arbitration,
// misalignment, reset abort and a MEM_LATENCY=1 instance.
module tb_pipeline_mem_arbiter;

  logic clk, rst;
  logic if_req, im_req, im_rw, use_over;
  logic [31:0] if_addr, im_addr, im_wdata;
  logic [1:0]  im_access_size;
  logic [31:0] if_rdata, im_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_valid, im_valid, im_err, mem_enable, mem_rw, stall_if, stall_pipe;
  logic [1:0] mem_access_size;

  logic b_if_req, b_if_valid, b_im_valid, b_im_err, b_mem_enable, b_mem_rw;
  logic b_stall_if, b_stall_pipe;
  logic [31:0] b_if_addr, b_if_rdata, b_im_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0] b_mem_access_size;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign mem_rdata   = use_over ? 32'hDEADBEEF : model(mem_addr);
  assign b_mem_rdata = model(b_mem_addr);

  pipeline_mem_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .im_req(im_req), .im_addr(im_addr), .im_wdata(im_wdata), .im_rw(im_rw),
    .im_access_size(im_access_size), .im_rdata(im_rdata), .im_valid(im_valid), .im_err(im_err),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_access_size(mem_access_size), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_pipe(stall_pipe)
  );

  pipeline_mem_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
    .im_req(1'b0), .im_addr(32'h0), .im_wdata(32'h0), .im_rw(1'b0),
    .im_access_size(2'b10), .im_rdata(b_im_rdata), .im_valid(b_im_valid), .im_err(b_im_err),
    .mem_enable(b_mem_enable), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rw(b_mem_rw), .mem_access_size(b_mem_access_size), .mem_rdata(b_mem_rdata),
    .stall_if(b_stall_if), .stall_pipe(b_stall_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic [1:0]  size;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  logic t_valid, t_err, t_saw_en, t_rw, t_st0, t_st1;
  logic [1:0] t_sz;
  logic [31:0] t_addr, t_wd;
  int t_cyc;

  task automatic im_op(input logic [31:0] a, input logic [31:0] w, input logic rw,
                       input logic [1:0] sz);
    @(negedge clk);
    im_req = 1'b1; im_addr = a; im_wdata = w; im_rw = rw; im_access_size = sz;
    #1 t_st0 = stall_pipe;
    t_valid = 1'b0; t_err = 1'b0; t_saw_en = 1'b0; t_cyc = 0; t_st1 = 1'b1;
    t_rw = 1'bx; t_sz = 2'bxx; t_addr = 'x; t_wd = 'x;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      t_cyc++;
      if (mem_enable) begin
        t_saw_en = 1'b1; t_rw = mem_rw; t_sz = mem_access_size; t_addr = mem_addr;
        t_wd = mem_wdata;
      end
      if (im_valid || im_err) begin
        t_valid = im_valid; t_err = im_err; t_st1 = stall_pipe;
        break;
      end
    end
    im_req = 1'b0;
    @(negedge clk);
  endtask

  int cnt;
  logic [2:0] ord;
  logic [31:0] a1, a3, a5;

  initial begin
    rst = 1'b1; use_over = 1'b0;
    if_req = 1'b0; if_addr = '0; im_req = 1'b0; im_addr = '0; im_wdata = '0; im_rw = 1'b0;
    im_access_size = 2'b10; b_if_req = 1'b0; b_if_addr = '0;

    vecs[0] = '{32'h200, 32'h0,       1'b0, 2'b10, 1'b0, model(32'h200)};
    vecs[1] = '{32'h204, 32'h12345678, 1'b1, 2'b10, 1'b0, model(32'h200)};
    vecs[2] = '{32'h301, 32'h0,       1'b0, 2'b01, 1'b1, model(32'h200)};
    vecs[3] = '{32'h302, 32'h0,       1'b0, 2'b01, 1'b0, model(32'h302)};
    vecs[4] = '{32'h303, 32'h0,       1'b0, 2'b00, 1'b0, model(32'h303)};
    vecs[5] = '{32'h402, 32'h0,       1'b0, 2'b10, 1'b1, model(32'h303)};
    vecs[6] = '{32'h400, 32'h0,       1'b0, 2'b11, 1'b1, model(32'h303)};
    vecs[7] = '{32'h500, 32'hA5A5A5A5, 1'b1, 2'b01, 1'b0, model(32'h303)};

    // Reset state
    @(negedge clk);
    chk("rst mem_enable", mem_enable, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_size", mem_access_size, 0);
    chk("rst valids", {if_valid, im_valid, im_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single IF read, latency 2
    @(negedge clk);
    use_over = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    #1 chk("A stall_if c0", stall_if, 1);
    chk("A mem_enable c0", mem_enable, 0);
    @(negedge clk);
    chk("A mem_enable c1", mem_enable, 1);
    chk("A mem_addr c1", mem_addr, 32'h100);
    chk("A mem_size c1", mem_access_size, 2'b10);
    chk("A mem_rw c1", mem_rw, 0);
    chk("A stall_if c1", stall_if, 1);
    @(negedge clk);
    chk("A mem_enable c2", mem_enable, 1);
    chk("A if_valid c2", if_valid, 0);
    chk("A stall_if c2", stall_if, 1);
    @(negedge clk);
    chk("A if_valid c3", if_valid, 1);
    chk("A if_rdata c3", if_rdata, 32'hDEADBEEF);
    chk("A stall_if c3", stall_if, 0);
    chk("A mem_enable c3", mem_enable, 0);
    if_req = 1'b0;
    @(negedge clk);
    chk("A if_valid c4", if_valid, 0);
    use_over = 1'b0;

    // IM decode / access table
    for (int i = 0; i < 8; i++) begin
      im_op(vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].size);
      chk($sformatf("vec%0d err", i), t_err, vecs[i].exp_err);
      chk($sformatf("vec%0d valid", i), t_valid, !vecs[i].exp_err);
      chk($sformatf("vec%0d cycles", i), t_cyc, vecs[i].exp_err ? 1 : 3);
      chk($sformatf("vec%0d im_rdata", i), im_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d mem_enable seen", i), t_saw_en, !vecs[i].exp_err);
      chk($sformatf("vec%0d stall start", i), t_st0, 1);
      chk($sformatf("vec%0d stall done", i), t_st1, 0);
      chk($sformatf("vec%0d pulse cleared", i), {im_valid, im_err}, 0);
      if (!vecs[i].exp_err) begin
        chk($sformatf("vec%0d mem_rw", i), t_rw, vecs[i].rw);
        chk($sformatf("vec%0d mem_size", i), t_sz, vecs[i].size);
        chk($sformatf("vec%0d mem_addr", i), t_addr, vecs[i].addr);
        chk($sformatf("vec%0d mem_wdata", i), t_wd, vecs[i].wdata);
      end
    end

    // Both requesting continuously: IM, IF, IM with no gap
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    im_req = 1'b1; im_addr = 32'h600; im_rw = 1'b0; im_access_size = 2'b10;
    cnt = 0; ord = '0; a1 = '0; a3 = '0; a5 = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (mem_enable) cnt++;
      if (im_valid || if_valid) ord = {ord[1:0], im_valid};
      if (k == 1) a1 = mem_addr;
      if (k == 3) a3 = mem_addr;
      if (k == 5) a5 = mem_addr;
    end
    chk("B enable cycles", cnt, 7);
    chk("B completion order", ord, 3'b101);
    chk("B grant1 addr", a1, 32'h600);
    chk("B grant2 addr", a3, 32'h100);
    chk("B grant3 addr", a5, 32'h600);
    chk("B im_rdata", im_rdata, model(32'h600));
    if_req = 1'b0; im_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cnt++;
      if (if_valid) break;
    end
    chk("B dropped IF completes", cnt, 2);
    chk("B if_rdata", if_rdata, model(32'h100));
    @(negedge clk);
    chk("B idle after", mem_enable, 0);

    // Misaligned IM with pending IF granted on the same edge
    @(negedge clk);
    im_req = 1'b1; im_addr = 32'h301; im_access_size = 2'b01; im_rw = 1'b0;
    if_req = 1'b1; if_addr = 32'h140;
    @(negedge clk);
    chk("C im_err", im_err, 1);
    chk("C im_valid", im_valid, 0);
    chk("C stall_pipe", stall_pipe, 0);
    chk("C IF granted", {mem_enable, mem_addr}, {1'b1, 32'h140});
    im_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cnt++;
      if (if_valid) break;
    end
    chk("C IF latency", cnt, 2);
    chk("C if_rdata", if_rdata, model(32'h140));
    chk("C im_err cleared", im_err, 0);
    if_req = 1'b0;
    @(negedge clk);

    // Reset during IM_BUSY with counter=1
    @(negedge clk);
    im_req = 1'b1; im_addr = 32'h700; im_wdata = 32'hCAFE0001; im_access_size = 2'b10;
    @(negedge clk);
    chk("D busy before rst", mem_enable, 1);
    im_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("D mem_enable", mem_enable, 0);
    chk("D mem_addr", mem_addr, 0);
    chk("D mem_wdata", mem_wdata, 0);
    chk("D mem_rw/size", {mem_rw, mem_access_size}, 0);
    chk("D if_rdata", if_rdata, 0);
    chk("D im_rdata", im_rdata, 0);
    chk("D pulses", {if_valid, im_valid, im_err}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (im_valid) cnt++;
    end
    chk("D no im_valid", cnt, 0);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h180;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cnt++;
      if (if_valid) break;
    end
    chk("D IF latency", cnt, 3);
    chk("D if_rdata", if_rdata, model(32'h180));
    if_req = 1'b0;

    // MEM_LATENCY=1 back-to-back IF reads
    @(negedge clk);
    b_if_req = 1'b1; b_if_addr = 32'h0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cnt++;
      if (b_if_valid) break;
    end
    chk("E read0 latency", cnt, 2);
    chk("E read0 data", b_if_rdata, model(32'h0));
    b_if_addr = 32'h4;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cnt++;
      if (b_if_valid) break;
    end
    chk("E read1 latency", cnt, 2);
    chk("E read1 data", b_if_rdata, model(32'h4));
    b_if_req = 1'b0;
    @(negedge clk);
    chk("E idle", b_mem_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
